// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a single 4-bit ALU slice across a W-bit operand,
// one nibble per clock, LSB first, chaining carry between slices.
// Requests and results use valid/ready handshakes; one operation in flight.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   zero,
    output logic                   overflow,
    output logic                   carry,
    output logic                   size
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LT  = 3'b110,
        OP_EQ  = 3'b111
    } op_t;

    state_t         state;
    op_t            op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  count;
    logic           cin_q;

    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [3:0]     slice_res;
    logic [4:0]     slice_sum;
    logic           subtract;
    logic           arith;
    logic [W-1:0]   res_next;
    logic           zero_next;
    logic           ovf_next;
    logic           size_next;

    // One slice of the ALU plus the full-width flags seen once the current nibble lands
    always_comb begin
        subtract  = (op_q == OP_SUB) || (op_q == OP_LT) || (op_q == OP_EQ);
        arith     = subtract || (op_q == OP_ADD);
        a_nib     = a_q[{count, 2'b00} +: 4];
        b_nib     = b_q[{count, 2'b00} +: 4];
        slice_sum = {1'b0, a_nib} + {1'b0, (subtract ? ~b_nib : b_nib)} + {4'b0000, cin_q};
        case (op_q)
            OP_NOT:  slice_res = ~a_nib;
            OP_AND:  slice_res = a_nib & b_nib;
            OP_OR:   slice_res = a_nib | b_nib;
            OP_XOR:  slice_res = a_nib ^ b_nib;
            default: slice_res = slice_sum[3:0];
        endcase

        res_next = result;
        res_next[{count, 2'b00} +: 4] = slice_res;
        zero_next = (res_next == '0);

        ovf_next = 1'b0;
        if (op_q == OP_ADD)
            ovf_next = (a_q[W-1] == b_q[W-1]) && (res_next[W-1] != a_q[W-1]);
        else if (subtract)
            ovf_next = (a_q[W-1] != b_q[W-1]) && (res_next[W-1] != a_q[W-1]);

        size_next = 1'b0;
        if (op_q == OP_LT)
            size_next = res_next[W-1] ^ ovf_next;
        else if (op_q == OP_EQ)
            size_next = zero_next;
    end

    // Sequencer: accept, step nibbles, hold result until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            count     <= '0;
            cin_q     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            size      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op_t'(op);
                        count    <= '0;
                        cin_q    <= (op == OP_SUB) || (op == OP_LT) || (op == OP_EQ);
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    result <= res_next;
                    cin_q  <= slice_sum[4];
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        zero      <= zero_next;
                        overflow  <= ovf_next;
                        carry     <= arith & slice_sum[4];
                        size      <= size_next;
                        count     <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Testbench for alu_nibble_seq: directed cases, backpressure, mid-run reset
// and random operations checked against a whole-word arithmetic model.
module tb_alu_nibble_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam longint MOD  = longint'(1) << W;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carry;
    logic         size;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry),
        .size      (size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: returns {result, zero, overflow, carry, size}
    function automatic logic [W+3:0] ref_model(input logic [2:0] f, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint ux, uy, sx, sy, s, full;
        logic [W-1:0] r;
        logic z, v, c, sz;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - MOD : ux;
        sy = y[W-1] ? uy - MOD : uy;
        v = 1'b0; c = 1'b0; sz = 1'b0; r = '0;
        case (f)
            3'd0: begin
                full = ux + uy;
                r = full[W-1:0];
                c = (full >= MOD);
                s = sx + sy;
                v = (s > SMAX) || (s < SMIN);
            end
            3'd1, 3'd6, 3'd7: begin
                full = ux - uy;
                r = full[W-1:0];
                c = (ux >= uy);
                s = sx - sy;
                v = (s > SMAX) || (s < SMIN);
                if (f == 3'd6) sz = (sx < sy);
                if (f == 3'd7) sz = (ux == uy);
            end
            3'd2: r = ~x;
            3'd3: r = x & y;
            3'd4: r = x | y;
            default: r = x ^ y;
        endcase
        z = (r == '0);
        return {r, z, v, c, sz};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        op = f; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // scramble inputs after the accept edge; they must not matter
        a  = W'($urandom);
        b  = W'($urandom);
        op = 3'($urandom);
    endtask

    task automatic wait_done();
        int unsigned lat = 1;
        check("busy_in_ready", in_ready, 0);
        tick();
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", lat, NIBBLES);
    endtask

    task automatic check_outputs(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W+3:0] e;
        e = ref_model(f, x, y);
        check("out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        check($sformatf("result op%0d %h,%h", f, x, y), result, e[W+3:4]);
        check($sformatf("zero op%0d %h,%h", f, x, y), zero, e[3]);
        check($sformatf("overflow op%0d %h,%h", f, x, y), overflow, e[2]);
        check($sformatf("carry op%0d %h,%h", f, x, y), carry, e[1]);
        check($sformatf("size op%0d %h,%h", f, x, y), size, e[0]);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(f, x, y);
        wait_done();
        check_outputs(f, x, y);
        release_result();
    endtask

    logic [2:0]   d_op [14] = '{3'd0, 3'd1, 3'd1, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7,
                                3'd5, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic [W-1:0] d_a  [14] = '{16'h7FFF, 16'h0000, 16'h8000, 16'hFFFE, 16'h8000, 16'h0003,
                                16'h1234, 16'h1234, 16'hF0F0, 16'h00FF, 16'h1234, 16'h1200,
                                16'h8000, 16'h0005};
    logic [W-1:0] d_b  [14] = '{16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h7FFF, 16'hFFFE,
                                16'h1234, 16'h1235, 16'hFFFF, 16'h5A5A, 16'h0F0F, 16'h0034,
                                16'h8000, 16'h0005};

    initial begin
        logic [2:0]   f;
        logic [W-1:0] x, y, hold_res;
        logic [W+3:0] e;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", {zero, overflow, carry, size}, 0);

        // spot checks of the model itself against hand-derived values
        e = ref_model(3'd0, 16'h7FFF, 16'h0001);
        check("model_add_ovf", e, {16'h8000, 4'b0100});
        e = ref_model(3'd6, 16'h8000, 16'h7FFF);
        check("model_lt_ovf", e, {16'h0001, 4'b0111});

        for (int i = 0; i < 14; i++) run_op(d_op[i], d_a[i], d_b[i]);

        // backpressure: DONE holds while a new request is offered
        issue(3'd0, 16'h1111, 16'h2222);
        wait_done();
        check_outputs(3'd0, 16'h1111, 16'h2222);
        hold_res = result;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'd5; a = 16'hAAAA; b = 16'h0F0F;
            tick();
            check("bp_result", result, hold_res);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        wait_done();
        check_outputs(3'd5, 16'hAAAA, 16'h0F0F);
        release_result();

        // reset two cycles into RUN
        issue(3'd0, 16'h1234, 16'h1111);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_result", result, 0);
        check("midrun_flags", {zero, overflow, carry, size}, 0);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_in_ready", in_ready, 1);
        issue(3'd0, 16'hFFFF, 16'h0001);
        wait_done();
        check_outputs(3'd0, 16'hFFFF, 16'h0001);
        check("wrap_result", result, 16'h0000);
        check("wrap_carry", carry, 1);
        check("wrap_zero", zero, 1);
        release_result();

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 3) == 0) y = x;
            run_op(f, x, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
Multi-cycle sequencer that runs one 4-bit ALU slice over a wide operand, one nibble per cycle, LSB first, chaining carry between slices. It gives the CPU datapath full-width add/sub/logic/compare results without a wide ALU. Requester and consumer sides both use valid/ready handshakes. The block holds one operation in flight at a time.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (min 1).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
op  input  3  000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal
a  input  W  operand A
b  input  W  operand B (ignored for op 010)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  W  result word
zero  output  1  result == 0
overflow  output  1  signed overflow
carry  output  1  carry out of MSB slice
size  output  1  compare outcome

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n): when rst_n=0 at a rising edge, state=IDLE, count=0, result=0, all flags=0, out_valid=0. in_ready=1 from the next cycle. Reset overrides every other event, including mid-RUN and DONE.
- States:
  - IDLE: in_ready=1, out_valid=0. An edge with in_valid=1 latches a, b, op, sets count=0, loads carry_in (1 for op 001/110/111, else 0), and moves to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge processes nibble[count], writes the result nibble, updates carry_in to the slice carry-out, and increments count. At count==NIBBLES-1 the flags are also registered and the state moves to DONE.
  - DONE: out_valid=1, in_ready=0. result and flags stay stable. An edge with out_ready=1 moves to IDLE. in_valid is ignored.
- Latency: if the request is accepted at edge E, out_valid=1 after edge E+NIBBLES. Minimum issue interval is NIBBLES+2 cycles.
- Inputs a, b and op are sampled only on the accept edge. Later changes have no effect.
- Slice arithmetic:
  - add: a+b+cin.
  - sub, lt, eq: a+~b+cin. carry=1 means no borrow.
  - Logic ops act per nibble. For logic ops, carry=overflow=size=0.
- Flags, using the full W-bit result:
  - zero = (result==0) for all ops.
  - add overflow = (a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
  - sub/lt/eq overflow = (a[W-1]!=b[W-1]) && (result[W-1]!=a[W-1]).
  - op 110: result = a-b, size = result[W-1] ^ overflow (1 iff a<b signed).
  - op 111: result = a-b, size = zero (1 iff a==b).
  - ops 000/001: size=0.
- Width: carry is the carry-out of the final slice only. Higher bits wrap.
- No output combinationally depends on any input. All outputs are registered or decoded from state.

Test Plan:
- add a=0x7FFF, b=0x0001 accepted at edge E -> out_valid first high after E+4; result=0x8000, overflow=1, carry=0, zero=0, size=0.
- sub 0x0000-0x0001 -> 0xFFFF, carry=0, overflow=0. sub 0x8000-0x0001 -> 0x7FFF, carry=1, overflow=1.
- lt: a=0xFFFE, b=0x0003 -> size=1. a=0x8000, b=0x7FFF -> result 0x0001, overflow=1, size=1. a=0x0003, b=0xFFFE -> size=0.
- eq a=b=0x1234 -> result 0x0000, zero=1, size=1. eq 0x1234 vs 0x1235 -> size=0. Logic ops: xor 0xF0F0^0xFFFF=0x0F0F, not 0x00FF=0xFF00, and 0x1234&0x0F0F=0x0204, or 0x1200|0x0034=0x1234, with carry/overflow/size=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while asserting in_valid with new operands -> result/flags unchanged, in_ready=0, request not taken. Raise out_ready -> IDLE next cycle, then the new request is accepted.
- rst_n=0 for one edge two cycles into RUN -> after that edge result=0, flags=0, out_valid=0, in_ready=1. Then add 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1, overflow=0.
